// File: rtl/uart_rx_frame_pkg.sv
// Shared definitions for the UART receive framer.
// Contents: receive FSM state encoding, legal character-length limits,
// the error-status payload and the parity-check helper.
package uart_rx_frame_pkg;

  localparam int unsigned DATA_BITS_MIN = 5;
  localparam int unsigned DATA_BITS_MAX = 8;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // Error status attached to a received character
  typedef struct packed {
    logic perr;
    logic ferr;
  } rx_err_t;

  // Parity mismatch: XOR of data bits, received parity bit and odd-select must be 0
  function automatic logic parity_err(input logic xor_data, input logic par_bit,
                                      input logic odd);
    return xor_data ^ par_bit ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rxd synchroniser and falling-edge detector.
// Ports:
//   clk, rst_n : system clock, synchronous active-low reset
//   rxd        : asynchronous serial input (idle high)
//   sync       : synchronised rxd (last synchroniser stage)
//   fall       : 1-cycle pulse, registered; high in the cycle sync first reads 0 after 1
module uart_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd,
  output logic sync,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stages_q;

  // Synchroniser chain resets to the idle level; fall compares the outgoing
  // sync value with the one about to replace it, i.e. prev_sync & ~sync.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stages_q <= '1;
      fall     <= 1'b0;
    end else begin
      stages_q <= {stages_q[SYNC_STAGES-2:0], rxd};
      fall     <= stages_q[SYNC_STAGES-1] & ~stages_q[SYNC_STAGES-2];
    end
  end

  assign sync = stages_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: detects a start edge, drives the baud generator
// start/finish strobes, samples bits on mid-bit ticks and commits an
// LSB-first character with status into a holding register.
// Ports:
//   clk, rst_n    : system clock, synchronous active-low reset
//   rxd           : asynchronous serial input, idle high
//   baud_tick     : mid-bit pulse from the baud generator
//   baud_start    : 1-cycle pulse starting the baud generator
//   baud_finish   : 1-cycle pulse stopping the baud generator
//   rx_data       : last received character
//   rx_full       : unread character present
//   rx_ack        : read strobe, clears rx_full/rx_ovr/rx_perr/rx_ferr
//   rx_perr       : parity error of rx_data
//   rx_ferr       : framing error (stop bit low) of rx_data
//   rx_ovr        : sticky overrun
//   rx_busy       : frame in progress
module uart_rx_frame
  import uart_rx_frame_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_EN   = 0,
  parameter int unsigned PARITY_ODD  = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  input  logic                 baud_tick,
  output logic                 baud_start,
  output logic                 baud_finish,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_full,
  input  logic                 rx_ack,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_ovr,
  output logic                 rx_busy
);

  localparam int unsigned CNT_W = $clog2(DATA_BITS);

  logic sync;
  logic fall;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .rxd  (rxd),
    .sync (sync),
    .fall (fall)
  );

  rx_state_e            state_q;
  rx_state_e            state_d;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 xor_q;
  rx_err_t              err_pend_q;

  logic start_c;
  logic finish_c;
  logic commit_c;
  logic shift_en_c;
  logic clr_cnt_c;
  logic par_cap_c;

  // Next-state and per-cycle strobes
  always_comb begin
    state_d    = state_q;
    start_c    = 1'b0;
    finish_c   = 1'b0;
    commit_c   = 1'b0;
    shift_en_c = 1'b0;
    clr_cnt_c  = 1'b0;
    par_cap_c  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (fall) begin
          state_d = RX_START;
          start_c = 1'b1;
        end
      end
      RX_START: begin
        if (baud_tick) begin
          if (sync) begin
            // Start bit gone high again by mid-bit: glitch, abandon quietly
            state_d  = RX_IDLE;
            finish_c = 1'b1;
          end else begin
            state_d   = RX_DATA;
            clr_cnt_c = 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (baud_tick) begin
          shift_en_c = 1'b1;
          if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
            state_d = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
          end
        end
      end
      RX_PARITY: begin
        if (baud_tick) begin
          par_cap_c = 1'b1;
          state_d   = RX_STOP;
        end
      end
      RX_STOP: begin
        if (baud_tick) begin
          finish_c = 1'b1;
          commit_c = 1'b1;
          state_d  = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RX_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      xor_q       <= 1'b0;
      err_pend_q  <= '0;
      baud_start  <= 1'b0;
      baud_finish <= 1'b0;
      rx_busy     <= 1'b0;
      rx_data     <= '0;
      rx_full     <= 1'b0;
      rx_perr     <= 1'b0;
      rx_ferr     <= 1'b0;
      rx_ovr      <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_start  <= start_c;
      baud_finish <= finish_c;
      rx_busy     <= (state_d != RX_IDLE);

      if (clr_cnt_c) begin
        bit_cnt_q  <= '0;
        xor_q      <= 1'b0;
        err_pend_q <= '0;
      end
      // LSB arrives first, so shifting in at the MSB leaves bit 0 in shift_q[0]
      if (shift_en_c) begin
        shift_q   <= {sync, shift_q[DATA_BITS-1:1]};
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        xor_q     <= xor_q ^ sync;
      end
      if (par_cap_c) begin
        err_pend_q.perr <= parity_err(xor_q, sync, 1'(PARITY_ODD));
      end

      // Commit beats a coincident read; the read still clears overrun
      if (commit_c) begin
        rx_data <= shift_q;
        rx_ferr <= ~sync;
        rx_perr <= (PARITY_EN != 0) ? err_pend_q.perr : 1'b0;
        rx_full <= 1'b1;
        rx_ovr  <= rx_ack ? 1'b0 : (rx_ovr | rx_full);
      end else if (rx_ack) begin
        rx_full <= 1'b0;
        rx_ovr  <= 1'b0;
        rx_perr <= 1'b0;
        rx_ferr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: one 8N1 instance and one 8E1 instance, each paired
// with a behavioural baud generator (tick period 435 clks, first tick ~218
// clks after baud_start).
module tb_uart_rx_frame;

  localparam int BIT_CLKS   = 435;
  localparam int TICK_PHASE = 217;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rxd_a, rxd_p;
  logic ack_a, ack_p;
  logic tick_a, tick_p;
  logic bstart_a, bfin_a, full_a, perr_a, ferr_a, ovr_a, busy_a;
  logic bstart_p, bfin_p, full_p, perr_p, ferr_p, ovr_p, busy_p;
  logic [7:0] data_a, data_p;

  uart_rx_frame #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_a), .baud_tick(tick_a),
    .baud_start(bstart_a), .baud_finish(bfin_a), .rx_data(data_a), .rx_full(full_a),
    .rx_ack(ack_a), .rx_perr(perr_a), .rx_ferr(ferr_a), .rx_ovr(ovr_a), .rx_busy(busy_a)
  );

  uart_rx_frame #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .SYNC_STAGES(2)) dut_p (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_p), .baud_tick(tick_p),
    .baud_start(bstart_p), .baud_finish(bfin_p), .rx_data(data_p), .rx_full(full_p),
    .rx_ack(ack_p), .rx_perr(perr_p), .rx_ferr(ferr_p), .rx_ovr(ovr_p), .rx_busy(busy_p)
  );

  // Behavioural baud generators
  logic run_a = 1'b0, run_p = 1'b0;
  int   ph_a = 0, ph_p = 0;

  always @(posedge clk) begin
    if (!rst_n || bfin_a) run_a <= 1'b0;
    else if (bstart_a) begin run_a <= 1'b1; ph_a <= 0; end
    else if (run_a) ph_a <= (ph_a == BIT_CLKS - 1) ? 0 : ph_a + 1;
  end
  always @(posedge clk) begin
    if (!rst_n || bfin_p) run_p <= 1'b0;
    else if (bstart_p) begin run_p <= 1'b1; ph_p <= 0; end
    else if (run_p) ph_p <= (ph_p == BIT_CLKS - 1) ? 0 : ph_p + 1;
  end
  assign tick_a = run_a && (ph_a == TICK_PHASE);
  assign tick_p = run_p && (ph_p == TICK_PHASE);

  // Strobe counters
  int starts_a = 0, fins_a = 0, starts_p = 0, fins_p = 0, overlap = 0;
  always @(posedge clk) begin
    if (bstart_a) starts_a <= starts_a + 1;
    if (bfin_a)   fins_a   <= fins_a + 1;
    if (bstart_p) starts_p <= starts_p + 1;
    if (bfin_p)   fins_p   <= fins_p + 1;
    if ((bstart_a && bfin_a) || (bstart_p && bfin_p)) overlap <= overlap + 1;
  end

  int compared = 0;
  int failed   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic b, input int n);
    if (sel) rxd_p = b; else rxd_a = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en,
                            input logic par, input logic stop);
    drive(sel, 1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive(sel, d[i], BIT_CLKS);
    if (par_en) drive(sel, par, BIT_CLKS);
    drive(sel, stop, BIT_CLKS);
  endtask

  task automatic pulse_ack(input bit sel);
    if (sel) ack_p = 1'b1; else ack_a = 1'b1;
    @(negedge clk);
    ack_a = 1'b0;
    ack_p = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    bit         sel;
    logic [7:0] data;
    bit         par_en;
    logic       par;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;

  vec_t vecs[6];

  int s0, f0;
  logic [7:0] g_data;
  logic g_full, g_ferr, g_perr, g_ovr, g_busy;

  initial begin
    vecs[0] = '{0, 8'h55, 0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[1] = '{0, 8'hFF, 0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[2] = '{1, 8'h07, 1, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1};
    vecs[3] = '{1, 8'h07, 1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    vecs[4] = '{1, 8'h80, 1, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{1, 8'hC3, 1, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b0};

    rst_n = 1'b0; rxd_a = 1'b1; rxd_p = 1'b1; ack_a = 1'b0; ack_p = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_a_outputs", {data_a, full_a, ovr_a, ferr_a, perr_a, busy_a, bstart_a, bfin_a}, 32'h0);
    chk("reset_p_outputs", {data_p, full_p, ovr_p, ferr_p, perr_p, busy_p, bstart_p, bfin_p}, 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Table-driven frames, each preceded by a read so status is fresh
    for (int v = 0; v < 6; v++) begin
      pulse_ack(vecs[v].sel);
      s0 = vecs[v].sel ? starts_p : starts_a;
      f0 = vecs[v].sel ? fins_p : fins_a;
      send_frame(vecs[v].sel, vecs[v].data, vecs[v].par_en, vecs[v].par, vecs[v].stop);
      if (vecs[v].sel) begin
        g_data = data_p; g_full = full_p; g_ferr = ferr_p; g_perr = perr_p; g_ovr = ovr_p; g_busy = busy_p;
        chk($sformatf("v%0d_starts", v), starts_p - s0, 1);
        chk($sformatf("v%0d_finishes", v), fins_p - f0, 1);
      end else begin
        g_data = data_a; g_full = full_a; g_ferr = ferr_a; g_perr = perr_a; g_ovr = ovr_a; g_busy = busy_a;
        chk($sformatf("v%0d_starts", v), starts_a - s0, 1);
        chk($sformatf("v%0d_finishes", v), fins_a - f0, 1);
      end
      chk($sformatf("v%0d_data", v), g_data, vecs[v].exp_data);
      chk($sformatf("v%0d_full", v), g_full, 1);
      chk($sformatf("v%0d_ferr", v), g_ferr, vecs[v].exp_ferr);
      chk($sformatf("v%0d_perr", v), g_perr, vecs[v].exp_perr);
      chk($sformatf("v%0d_ovr", v), g_ovr, 0);
      chk($sformatf("v%0d_busy", v), g_busy, 0);
      drive(vecs[v].sel, 1'b1, 40);
    end

    // 0xA3 with low stop bit, then line held low: no restart
    pulse_ack(0);
    s0 = starts_a; f0 = fins_a;
    send_frame(0, 8'hA3, 0, 1'b0, 1'b0);
    drive(0, 1'b0, 5 * BIT_CLKS);
    chk("brk_data", data_a, 8'hA3);
    chk("brk_ferr", ferr_a, 1);
    chk("brk_full", full_a, 1);
    chk("brk_starts", starts_a - s0, 1);
    chk("brk_finishes", fins_a - f0, 1);
    drive(0, 1'b1, 100);
    chk("brk_release_starts", starts_a - s0, 1);

    // 100-clk glitch on idle line: false start
    pulse_ack(0);
    s0 = starts_a; f0 = fins_a;
    drive(0, 1'b0, 100);
    drive(0, 1'b1, 50);
    chk("glitch_busy", busy_a, 1);
    drive(0, 1'b1, 500);
    chk("glitch_starts", starts_a - s0, 1);
    chk("glitch_finishes", fins_a - f0, 1);
    chk("glitch_full", full_a, 0);
    chk("glitch_busy_end", busy_a, 0);

    // Overrun: two frames without a read
    send_frame(0, 8'h11, 0, 1'b0, 1'b1);
    drive(0, 1'b1, 20);
    chk("ovr_first_ovr", ovr_a, 0);
    send_frame(0, 8'h22, 0, 1'b0, 1'b1);
    drive(0, 1'b1, 20);
    chk("ovr_data", data_a, 8'h22);
    chk("ovr_flag", ovr_a, 1);
    chk("ovr_full", full_a, 1);
    pulse_ack(0);
    chk("ovr_ack_full", full_a, 0);
    chk("ovr_ack_ovr", ovr_a, 0);

    // Reset in the middle of data bit 4, with an unread character held
    send_frame(0, 8'h5A, 0, 1'b0, 1'b1);
    drive(0, 1'b1, 20);
    chk("pre_rst_full", full_a, 1);
    drive(0, 1'b0, BIT_CLKS);          // start bit
    drive(0, 1'b0, 4 * BIT_CLKS);      // bits 0..3 of 0xF0
    drive(0, 1'b1, 200);               // into bit 4
    chk("mid_frame_busy", busy_a, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs", {data_a, full_a, ovr_a, ferr_a, perr_a, busy_a, bstart_a, bfin_a}, 32'h0);
    rst_n = 1'b1;
    drive(0, 1'b1, 235 + 4 * BIT_CLKS);
    chk("rst_mid_no_commit", full_a, 0);
    s0 = starts_a;
    send_frame(0, 8'h3C, 0, 1'b0, 1'b1);
    drive(0, 1'b1, 20);
    chk("post_rst_data", data_a, 8'h3C);
    chk("post_rst_full", full_a, 1);
    chk("post_rst_ferr", ferr_a, 0);
    chk("post_rst_ovr", ovr_a, 0);
    chk("post_rst_starts", starts_a - s0, 1);

    chk("start_finish_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
